// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation pump scheduler.
//   state_t   : FSM state encoding (also exported on state_dbg)
//   SEG_*     : 7-segment codes shown per state
//   max3      : constant helper used to size the phase counter
//   seg_code  : display code for a given state / granted zone / fault status
package irrigation_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      WATER  = 2'd2,
      SETTLE = 2'd3
   } state_t;

   localparam logic [7:0] SEG_IDLE   = 8'h00;
   localparam logic [7:0] SEG_Z0     = 8'h3F;
   localparam logic [7:0] SEG_Z1     = 8'h06;
   localparam logic [7:0] SEG_SETTLE = 8'h40;
   localparam logic [7:0] SEG_FAULT  = 8'h79;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [7:0] seg_code(input state_t st, input logic zone,
                                           input logic any_fault);
      logic [7:0] code;
      code = SEG_IDLE;
      case (st)
         IDLE:         code = any_fault ? SEG_FAULT : SEG_IDLE;
         PRIME, WATER: code = zone ? SEG_Z1 : SEG_Z0;
         SETTLE:       code = SEG_SETTLE;
         default:      code = SEG_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/irrigation_scheduler_if.sv
// Board-side signal bundle of the irrigation scheduler.
//   enable, dry                      : controls / zone switches (master drives)
//   valve, pump, busy, zone_fault,
//   seg, state_dbg                   : actuator and status outputs (slave drives)
interface irrigation_scheduler_if;
   logic       enable;
   logic [1:0] dry;
   logic [1:0] valve;
   logic       pump;
   logic       busy;
   logic [1:0] zone_fault;
   logic [7:0] seg;
   logic [1:0] state_dbg;

   modport master (
      output enable, dry,
      input  valve, pump, busy, zone_fault, seg, state_dbg
   );

   modport slave (
      input  enable, dry,
      output valve, pump, busy, zone_fault, seg, state_dbg
   );
endinterface

// File: rtl/irrigation_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0] : requesting zones
//   last     : zone granted most recently; loses a tie
//   gnt      : any request present
//   gnt_zone : winning zone index
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       gnt_zone
);
   always_comb begin
      gnt      = |req;
      gnt_zone = 1'b0;
      case (req)
         2'b01:   gnt_zone = 1'b0;
         2'b10:   gnt_zone = 1'b1;
         2'b11:   gnt_zone = ~last;
         default: gnt_zone = 1'b0;
      endcase
   end
endmodule

// File: rtl/irrigation_scheduler.sv
// Shared-pump scheduler for two irrigation zones: arbitrates dry zones,
// sequences prime / water / settle, and latches per-zone timeout faults.
//   clk_2 : clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : enable/dry in; valve, pump, busy, zone_fault, seg, state_dbg out
module irrigation_scheduler
   import irrigation_pkg::*;
#(
   parameter int unsigned PRIME_TICKS     = 2,
   parameter int unsigned MAX_WATER_TICKS = 8,
   parameter int unsigned SETTLE_TICKS    = 3,
   parameter int unsigned FAULT_LIMIT     = 3
) (
   input  logic                 clk_2,
   input  logic                 reset,
   irrigation_scheduler_if.slave bus
);

   localparam int unsigned CNT_W  = $clog2(max3(PRIME_TICKS, MAX_WATER_TICKS, SETTLE_TICKS) + 1);
   localparam int unsigned FAIL_W = $clog2(FAULT_LIMIT + 1);

   state_t              state_q, state_d;
   logic                gz_q, gz_d;
   logic                last_q, last_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FAIL_W-1:0]   fail_q [2];
   logic [FAIL_W-1:0]   fail_d [2];
   logic [1:0]          fault_q, fault_d;
   logic [1:0]          dry_q;

   logic [1:0]          valve_q, valve_d;
   logic                pump_q, pump_d;
   logic                busy_q, busy_d;
   logic [7:0]          seg_q, seg_d;

   logic [1:0]          eligible;
   logic                gnt;
   logic                gnt_zone;

   assign eligible = dry_q & ~fault_q & {2{bus.enable}};

   rr_arbiter2 u_arb (
      .req      (eligible),
      .last     (last_q),
      .gnt      (gnt),
      .gnt_zone (gnt_zone)
   );

   // Next-state, counters and fault accounting
   always_comb begin
      state_d = state_q;
      gz_d    = gz_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: begin
            if (gnt) begin
               gz_d    = gnt_zone;
               last_d  = gnt_zone;
               cnt_d   = '0;
               state_d = PRIME;
            end
         end
         PRIME: begin
            if (!bus.enable) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(PRIME_TICKS - 1)) begin
               state_d = WATER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WATER: begin
            if (!bus.enable) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else if (!dry_q[gz_q]) begin
               state_d      = SETTLE;
               cnt_d        = '0;
               fail_d[gz_q] = '0;
            end else if (cnt_q == CNT_W'(MAX_WATER_TICKS - 1)) begin
               state_d = SETTLE;
               cnt_d   = '0;
               // Saturating count; the fault latches on the step that reaches the limit
               if (fail_q[gz_q] != FAIL_W'(FAULT_LIMIT)) begin
                  fail_d[gz_q] = fail_q[gz_q] + FAIL_W'(1);
                  if (fail_q[gz_q] + FAIL_W'(1) == FAIL_W'(FAULT_LIMIT)) begin
                     fault_d[gz_q] = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from next state so the registered pins line up with state_q
   always_comb begin
      valve_d = 2'b00;
      if ((state_d == PRIME) || (state_d == WATER)) begin
         valve_d = 2'(2'b01 << gz_d);
      end
      pump_d = (state_d == WATER);
      busy_d = (state_d != IDLE);
      seg_d  = seg_code(state_d, gz_d, |fault_d);
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q   <= IDLE;
         gz_q      <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         fail_q[0] <= '0;
         fail_q[1] <= '0;
         fault_q   <= 2'b00;
         dry_q     <= 2'b00;
         valve_q   <= 2'b00;
         pump_q    <= 1'b0;
         busy_q    <= 1'b0;
         seg_q     <= SEG_IDLE;
      end else begin
         state_q   <= state_d;
         gz_q      <= gz_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         fail_q[0] <= fail_d[0];
         fail_q[1] <= fail_d[1];
         fault_q   <= fault_d;
         dry_q     <= bus.dry;
         valve_q   <= valve_d;
         pump_q    <= pump_d;
         busy_q    <= busy_d;
         seg_q     <= seg_d;
      end
   end

   assign bus.valve      = valve_q;
   assign bus.pump       = pump_q;
   assign bus.busy       = busy_q;
   assign bus.zone_fault = fault_q;
   assign bus.seg        = seg_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler: directed scenarios plus a
// randomized run, all compared against a phase-level reference model.
module tb_irrigation_scheduler;

   localparam int PRIME_T  = 2;
   localparam int MAXW     = 8;
   localparam int SETTLE_T = 3;
   localparam int LIMIT    = 3;

   logic clk_2 = 1'b0;
   logic reset = 1'b1;

   irrigation_scheduler_if bus();

   irrigation_scheduler #(
      .PRIME_TICKS     (PRIME_T),
      .MAX_WATER_TICKS (MAXW),
      .SETTLE_TICKS    (SETTLE_T),
      .FAULT_LIMIT     (LIMIT)
   ) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk_2 = ~clk_2;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: phase number (0 idle,1 prime,2 water,3 settle) and cycles spent in it
   int         m_st, m_gz, m_last, m_el;
   int         m_fail [2];
   logic [1:0] m_fault, m_dryq;
   logic [1:0] e_valve, e_dbg;
   logic       e_pump, e_busy;
   logic [7:0] e_seg;

   task automatic model_step();
      logic [1:0] old_dry;
      logic [1:0] elig;
      if (reset) begin
         m_st = 0; m_gz = 0; m_last = 1; m_el = 0;
         m_fail[0] = 0; m_fail[1] = 0; m_fault = 2'b00; m_dryq = 2'b00;
      end else begin
         old_dry = m_dryq;
         case (m_st)
            0: begin
               elig = old_dry & ~m_fault & {2{bus.enable}};
               if (elig != 2'b00) begin
                  if (elig == 2'b11) m_gz = 1 - m_last;
                  else               m_gz = elig[1] ? 1 : 0;
                  m_last = m_gz; m_st = 1; m_el = 0;
               end
            end
            1: begin
               m_el++;
               if (!bus.enable)          begin m_st = 3; m_el = 0; end
               else if (m_el == PRIME_T) begin m_st = 2; m_el = 0; end
            end
            2: begin
               m_el++;
               if (!bus.enable) begin
                  m_st = 3; m_el = 0;
               end else if (!old_dry[m_gz]) begin
                  m_st = 3; m_el = 0; m_fail[m_gz] = 0;
               end else if (m_el == MAXW) begin
                  m_st = 3; m_el = 0;
                  if (m_fail[m_gz] < LIMIT) begin
                     m_fail[m_gz]++;
                     if (m_fail[m_gz] == LIMIT) m_fault[m_gz] = 1'b1;
                  end
               end
            end
            default: begin
               m_el++;
               if (m_el == SETTLE_T) begin m_st = 0; m_el = 0; end
            end
         endcase
         m_dryq = bus.dry;
      end
      e_valve = (m_st == 1 || m_st == 2) ? ((m_gz == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_pump  = (m_st == 2);
      e_busy  = (m_st != 0);
      e_dbg   = 2'(m_st);
      case (m_st)
         0:       e_seg = (m_fault != 2'b00) ? 8'h79 : 8'h00;
         1, 2:    e_seg = (m_gz == 1) ? 8'h06 : 8'h3F;
         default: e_seg = 8'h40;
      endcase
   endtask

   task automatic tick();
      @(posedge clk_2);
      model_step();
      @(negedge clk_2);
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      bus.enable = 1'b1;
      bus.dry    = 2'($urandom_range(0, 3));
      apply_reset(2);
      got = {bus.valve, bus.pump, bus.busy, bus.zone_fault, bus.seg, bus.state_dbg};
      vectors++;
      if (got !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_state: got %h expected 0000", got);
      end
   endtask

   task automatic test_single_zone();
      int  n_prime = 0, n_pump = 0, n_settle = 0;
      bit  done = 0;
      bus.dry = 2'b00;
      apply_reset(1);
      bus.dry = 2'b01;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         vectors++;
         if (bus.valve !== e_valve || bus.pump !== e_pump || bus.seg !== e_seg) begin
            miscompares++;
            $display("FAIL single_cycle%0d: got v=%b p=%b s=%h expected v=%b p=%b s=%h",
                     c, bus.valve, bus.pump, bus.seg, e_valve, e_pump, e_seg);
         end
         if (bus.state_dbg == 2'd1) n_prime++;
         if (bus.state_dbg == 2'd3) n_settle++;
         if (bus.pump) begin
            n_pump++;
            if (n_pump == 3) bus.dry = 2'b00;
         end
         if (n_settle > 0 && bus.state_dbg == 2'd0) done = 1;
      end
      vectors++;
      if (!done || n_prime != 2 || n_pump != 4 || n_settle != 3 || bus.seg !== 8'h00) begin
         miscompares++;
         $display("FAIL single_phases: got prime=%0d pump=%0d settle=%0d seg=%h done=%0d expected 2 4 3 00 1",
                  n_prime, n_pump, n_settle, bus.seg, done);
      end
   endtask

   task automatic test_round_robin();
      int   grants[$];
      int   exp_order[4] = '{0, 1, 0, 1};
      logic prev_busy = 1'b0;
      int   wcyc = 0;
      bus.dry = 2'b00;
      apply_reset(1);
      bus.dry = 2'b11;
      for (int c = 0; c < 200 && grants.size() < 4; c++) begin
         tick();
         vectors++;
         if (bus.valve !== e_valve) begin
            miscompares++;
            $display("FAIL rr_valve: got %b expected %b", bus.valve, e_valve);
         end
         if (bus.busy && !prev_busy) grants.push_back(bus.valve[1] ? 1 : 0);
         prev_busy = bus.busy;
         if (bus.pump) begin
            wcyc++;
            if (wcyc == 1) bus.dry[bus.valve[1]] = 1'b0;
         end
         if (bus.state_dbg == 2'd3) begin
            bus.dry = 2'b11;
            wcyc    = 0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (i >= grants.size()) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got none expected %0d", i, exp_order[i]);
         end else if (grants[i] != exp_order[i]) begin
            miscompares++;
            $display("FAIL rr_grant%0d: got %0d expected %0d", i, grants[i], exp_order[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int episodes = 0, wlen = 0;
      bus.dry = 2'b00;
      apply_reset(1);
      bus.dry = 2'b10;
      for (int c = 0; c < 300 && episodes < 3; c++) begin
         tick();
         vectors++;
         if (bus.pump !== e_pump || bus.zone_fault !== m_fault) begin
            miscompares++;
            $display("FAIL timeout_cycle: got p=%b f=%b expected p=%b f=%b",
                     bus.pump, bus.zone_fault, e_pump, m_fault);
         end
         if (bus.pump) wlen++;
         else if (wlen > 0) begin
            episodes++;
            vectors++;
            if (wlen != MAXW) begin
               miscompares++;
               $display("FAIL timeout_len%0d: got %0d expected %0d", episodes, wlen, MAXW);
            end
            wlen = 0;
         end
      end
      repeat (SETTLE_T + 1) tick();
      for (int i = 0; i < 20; i++) begin
         tick();
         vectors++;
         if (bus.busy !== 1'b0 || bus.zone_fault !== 2'b10 || bus.seg !== 8'h79) begin
            miscompares++;
            $display("FAIL fault_idle: got busy=%b f=%b seg=%h expected 0 10 79",
                     bus.busy, bus.zone_fault, bus.seg);
         end
      end
   endtask

   task automatic test_abort();
      int episodes = 0, wlen = 0;
      bus.dry = 2'b00;
      apply_reset(1);
      bus.dry    = 2'b01;
      bus.enable = 1'b1;
      for (int c = 0; c < 400 && episodes < 4; c++) begin
         tick();
         vectors++;
         if (bus.pump !== e_pump || bus.zone_fault !== m_fault) begin
            miscompares++;
            $display("FAIL abort_cycle: got p=%b f=%b expected p=%b f=%b",
                     bus.pump, bus.zone_fault, e_pump, m_fault);
         end
         if (bus.pump) begin
            wlen++;
            if (episodes == 2 && wlen == 4) bus.enable = 1'b0;
         end else if (wlen > 0) begin
            if (episodes == 2) begin
               vectors++;
               if (bus.state_dbg !== 2'd3 || bus.zone_fault !== 2'b00 || wlen != 4) begin
                  miscompares++;
                  $display("FAIL abort_settle: got st=%0d f=%b len=%0d expected 3 00 4",
                           bus.state_dbg, bus.zone_fault, wlen);
               end
               bus.enable = 1'b1;
            end
            episodes++;
            wlen = 0;
         end
      end
      vectors++;
      if (bus.zone_fault !== 2'b01) begin
         miscompares++;
         $display("FAIL abort_failcnt: got f=%b expected 01", bus.zone_fault);
      end
   endtask

   task automatic test_reset_mid_water();
      bit hit = 0;
      bus.dry = 2'b11;
      for (int c = 0; c < 60 && !hit; c++) begin
         tick();
         if (bus.pump) hit = 1;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (!hit || bus.valve !== 2'b00 || bus.pump !== 1'b0 || bus.zone_fault !== 2'b00
          || bus.state_dbg !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got water=%0d v=%b p=%b f=%b st=%0d expected 1 00 0 00 0",
                  hit, bus.valve, bus.pump, bus.zone_fault, bus.state_dbg);
      end
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         tick();
         if (bus.busy) hit = 1;
      end
      vectors++;
      if (!hit || bus.valve !== 2'b01) begin
         miscompares++;
         $display("FAIL reset_first_grant: got busy=%0d v=%b expected 1 01", hit, bus.valve);
      end
   endtask

   task automatic test_random();
      bus.enable = 1'b1;
      apply_reset(1);
      for (int c = 0; c < 1500; c++) begin
         bus.enable = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 11) == 0) bus.dry = 2'($urandom_range(0, 3));
         reset = ($urandom_range(0, 249) == 0);
         tick();
         vectors++;
         if (bus.valve !== e_valve || bus.pump !== e_pump || bus.busy !== e_busy ||
             bus.zone_fault !== m_fault || bus.seg !== e_seg || bus.state_dbg !== e_dbg) begin
            miscompares++;
            $display("FAIL random_c%0d: got v=%b p=%b b=%b f=%b s=%h st=%0d expected v=%b p=%b b=%b f=%b s=%h st=%0d",
                     c, bus.valve, bus.pump, bus.busy, bus.zone_fault, bus.seg, bus.state_dbg,
                     e_valve, e_pump, e_busy, m_fault, e_seg, e_dbg);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.enable = 1'b1;
      bus.dry    = 2'b00;
      test_reset();
      test_single_zone();
      test_round_robin();
      test_timeout();
      test_abort();
      test_reset_mid_water();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
